// File: rtl/times_table_arbiter.sv
// times_table_arbiter: shares one fixed-latency times-table multiplier between
// two requesters. Each request is accepted, issued, waited on and completed
// before the next one is served. Round-robin arbitration by default.
// Define TT_ARB_FIXED_PRIORITY_EN to make requester 0 always win when both request.
module times_table_arbiter #(
  parameter int unsigned WIDTH   = 3,
  parameter int unsigned LATENCY = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0,
  input  logic [WIDTH-1:0]   a0,
  input  logic [WIDTH-1:0]   b0,
  output logic               ack0,
  output logic               done0,
  output logic [2*WIDTH-1:0] result0,
  input  logic               req1,
  input  logic [WIDTH-1:0]   a1,
  input  logic [WIDTH-1:0]   b1,
  output logic               ack1,
  output logic               done1,
  output logic [2*WIDTH-1:0] result1,
  output logic [WIDTH-1:0]   mul_a,
  output logic [WIDTH-1:0]   mul_b,
  output logic               mul_read,
  input  logic [2*WIDTH-1:0] mul_result
);

  localparam int unsigned CW = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic            sel;
  logic            win;

`ifdef TT_ARB_FIXED_PRIORITY_EN
  // Requester 0 wins whenever it asks; requester 1 only when 0 is idle.
  always_comb begin
    win = !req0;
  end
`else
  logic            last_grant;

  // Requester 0 wins if alone, or if both ask and 1 was granted last.
  always_comb begin
    win = !(req0 && (!req1 || last_grant));
  end
`endif

  // Request sequencer: grant, issue read strobe, count latency, report done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      cnt        <= '0;
      sel        <= 1'b0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      done0      <= 1'b0;
      done1      <= 1'b0;
      result0    <= '0;
      result1    <= '0;
      mul_a      <= '0;
      mul_b      <= '0;
      mul_read   <= 1'b0;
`ifndef TT_ARB_FIXED_PRIORITY_EN
      last_grant <= 1'b1;
`endif
    end else begin
      ack0     <= 1'b0;
      ack1     <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      mul_read <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req0 || req1) begin
            sel      <= win;
`ifndef TT_ARB_FIXED_PRIORITY_EN
            last_grant <= win;
`endif
            mul_a    <= win ? a1 : a0;
            mul_b    <= win ? b1 : b0;
            ack0     <= !win;
            ack1     <= win;
            mul_read <= 1'b1;
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt   <= CW'(LATENCY);
          state <= S_WAIT;
        end
        S_WAIT: begin
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            if (sel) begin
              result1 <= mul_result;
              done1   <= 1'b1;
            end else begin
              result0 <= mul_result;
              done0   <= 1'b1;
            end
            state <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
